// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART MMIO controller: register offsets relative
// to BASE_ADDR, CON bit positions and the TX sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [31:0] TXD_OFS = 32'h0;
    localparam logic [31:0] RXD_OFS = 32'h4;
    localparam logic [31:0] CON_OFS = 32'h8;

    // CON register bit positions
    localparam int CON_TX_IE    = 0;  // RW
    localparam int CON_RX_IE    = 1;  // RW
    localparam int CON_TX_DONE  = 2;  // W1C
    localparam int CON_RX_READY = 3;  // RO
    localparam int CON_FULL     = 4;  // RO
    localparam int CON_RX_OVR   = 5;  // W1C
    localparam int CON_TX_OVF   = 6;  // W1C
    localparam int CON_TX_IDLE  = 7;  // RO

    // TX sequencer states
    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_START   = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_mmio_ctrl_if
// MEM-stage peripheral bus seen by the UART controller.
//   addr     : word-aligned byte address
//   MemRead  : read strobe (rdata is combinational in the same cycle)
//   MemWrite : write strobe, takes effect at the clock edge
//   wdata    : write data
//   rdata    : read data, zero when not selected or not reading
// master = CPU side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface uart_mmio_ctrl_if;
    logic [31:0] addr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, MemRead, MemWrite, wdata, input rdata);
    modport slave  (input addr, MemRead, MemWrite, wdata, output rdata);
endinterface

// File: rtl/uart_mmio_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo_8
// Byte-wide synchronous FIFO used to buffer outgoing UART bytes.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (accepted when not full, or when a
//                pop happens in the same cycle)
//   pop, dout  : read request and head-of-queue data (show-ahead)
//   full,empty : status flags
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo_8 #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// uart_mmio_ctrl
// Memory-mapped controller sequencing the UART TX/RX engines from the CPU's
// MEM-stage bus. Registers: TXD (BASE), RXD (BASE+4), CON (BASE+8).
//   sysclk, reset : clock, asynchronous active-low reset
//   bus           : peripheral bus (slave modport)
//   tx_start      : one-cycle start pulse to uart_tx
//   tx_data       : byte for uart_tx, valid with tx_start, held afterwards
//   tx_busy       : uart_tx busy
//   rx_valid      : one-cycle pulse from uart_rx, rx_data valid
//   rx_data       : received byte
//   irq           : registered level interrupt
// -----------------------------------------------------------------------------
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    uart_mmio_ctrl_if.slave      bus,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 irq
);

    // ---------------- address decode ----------------
    logic sel_txd, sel_rxd, sel_con;
    logic txd_wr, rxd_rd, con_wr;

    assign sel_txd = (bus.addr == BASE_ADDR + TXD_OFS);
    assign sel_rxd = (bus.addr == BASE_ADDR + RXD_OFS);
    assign sel_con = (bus.addr == BASE_ADDR + CON_OFS);
    assign txd_wr  = bus.MemWrite & sel_txd;
    assign rxd_rd  = bus.MemRead  & sel_rxd;
    assign con_wr  = bus.MemWrite & sel_con;

    // ---------------- TX FIFO ----------------
    logic                          fifo_pop;
    logic [7:0]                    fifo_head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    sync_fifo_8 #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sysclk),
        .rst_n (reset),
        .push  (txd_wr),
        .pop   (fifo_pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- TX sequencer ----------------
    tx_state_t state, state_nx;
    logic      wait_cnt, wait_cnt_nx;
    logic      done_set;
    logic      tx_idle;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        tx_start    = 1'b0;
        fifo_pop    = 1'b0;
        done_set    = 1'b0;
        unique case (state)
            TX_IDLE: begin
                if (!fifo_empty && !tx_busy) state_nx = TX_START;
            end
            TX_START: begin
                tx_start    = 1'b1;
                fifo_pop    = 1'b1;
                wait_cnt_nx = 1'b0;
                state_nx    = TX_WAIT_HI;
            end
            TX_WAIT_HI: begin
                // Give the engine two cycles to raise busy; a single-cycle
                // engine may never show it, so move on regardless.
                if (tx_busy || wait_cnt) state_nx = TX_WAIT_LO;
                else                     wait_cnt_nx = 1'b1;
            end
            TX_WAIT_LO: begin
                if (!tx_busy) begin
                    state_nx = TX_IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state    <= TX_IDLE;
            wait_cnt <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            // Load the byte on entry to START so it is stable during the pulse
            // and held until the next start.
            if (state == TX_IDLE && state_nx == TX_START) tx_data <= fifo_head;
        end
    end

    assign tx_idle = (fifo_count == '0) && (state == TX_IDLE);

    // ---------------- registers and flags ----------------
    logic [7:0] last_txd;
    logic [7:0] rx_hold;
    logic       tx_ie, rx_ie;
    logic       tx_done, rx_ready, rx_ovr, tx_ovf;
    logic       ovr_set, ovf_set;

    // A read of RXD in the same cycle consumes the old byte, so no overrun.
    assign ovr_set = rx_valid & rx_ready & ~rxd_rd;
    assign ovf_set = txd_wr & fifo_full & ~fifo_pop;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            last_txd <= 8'h00;
            rx_hold  <= 8'h00;
            tx_ie    <= 1'b0;
            rx_ie    <= 1'b0;
            tx_done  <= 1'b0;
            rx_ready <= 1'b0;
            rx_ovr   <= 1'b0;
            tx_ovf   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (txd_wr) last_txd <= bus.wdata[7:0];
            if (con_wr) begin
                tx_ie <= bus.wdata[CON_TX_IE];
                rx_ie <= bus.wdata[CON_RX_IE];
            end
            // W1C flags: a hardware set in the same cycle beats the clear.
            tx_done <= done_set | (tx_done & ~(con_wr & bus.wdata[CON_TX_DONE]));
            rx_ovr  <= ovr_set  | (rx_ovr  & ~(con_wr & bus.wdata[CON_RX_OVR]));
            tx_ovf  <= ovf_set  | (tx_ovf  & ~(con_wr & bus.wdata[CON_TX_OVF]));
            if (rx_valid) begin
                rx_hold  <= rx_data;
                rx_ready <= 1'b1;
            end else if (rxd_rd) begin
                rx_ready <= 1'b0;
            end
            irq <= (tx_ie & tx_done) | (rx_ie & rx_ready);
        end
    end

    // ---------------- read mux ----------------
    logic [31:0] con_val;

    always_comb begin
        con_val               = '0;
        con_val[CON_TX_IE]    = tx_ie;
        con_val[CON_RX_IE]    = rx_ie;
        con_val[CON_TX_DONE]  = tx_done;
        con_val[CON_RX_READY] = rx_ready;
        con_val[CON_FULL]     = fifo_full;
        con_val[CON_RX_OVR]   = rx_ovr;
        con_val[CON_TX_OVF]   = tx_ovf;
        con_val[CON_TX_IDLE]  = tx_idle;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.MemRead) begin
            if (sel_txd)      bus.rdata = {24'h0, last_txd};
            else if (sel_rxd) bus.rdata = {24'h0, rx_hold};
            else if (sel_con) bus.rdata = con_val;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_mmio_ctrl
// Self-checking bench for uart_mmio_ctrl: register-access vector table,
// TX byte scoreboard fed on TXD writes and drained on tx_start, a simple
// uart_tx busy model and hand-written sequences for the timing corners.
// -----------------------------------------------------------------------------
module tb_uart_mmio_ctrl;

    localparam logic [31:0] BASE  = 32'h4000_0018;
    localparam logic [31:0] A_TXD = BASE;
    localparam logic [31:0] A_RXD = BASE + 32'h4;
    localparam logic [31:0] A_CON = BASE + 32'h8;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       busy_hold = 1'b0;
    logic       busy_eng  = 1'b0;
    logic       rx_valid  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       irq;

    int         n_cmp    = 0;
    int         n_err    = 0;
    int         n_starts = 0;
    bit         eng_en   = 1'b0;
    int         busy_len = 10;
    logic [7:0] exp_q[$];

    always #5 sysclk = ~sysclk;
    assign tx_busy = busy_hold | busy_eng;

    uart_mmio_ctrl_if bus ();

    uart_mmio_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .bus      (bus),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .irq      (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: each tx_start must carry the next expected byte.
    initial begin
        forever begin
            @(negedge sysclk);
            if (tx_start === 1'b1) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_tx_start: got data 0x%02h with no byte pending", tx_data);
                end else begin
                    check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // uart_tx model: busy rises the cycle after start, stays for busy_len cycles.
    initial begin
        forever begin
            @(negedge sysclk);
            if (tx_start === 1'b1 && eng_en) begin
                @(posedge sysclk); #1 busy_eng = 1'b1;
                repeat (busy_len) @(posedge sysclk);
                #1 busy_eng = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    // Bus helpers: called at posedge+1, return at posedge+1.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.MemWrite = 1'b1;
        @(posedge sysclk); #1 bus.MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a; bus.MemRead = 1'b1;
        @(negedge sysclk); d = bus.rdata;
        @(posedge sysclk); #1 bus.MemRead = 1'b0;
    endtask

    task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        bus_read(a, v);
        check(name, v, exp);
    endtask

    task automatic wait_con(input logic [31:0] exp, input int budget, input string name);
        logic [31:0] v = '0;
        for (int i = 0; i < budget; i++) begin
            bus_read(A_CON, v);
            if (v === exp) break;
        end
        check(name, v, exp);
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sysclk);
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge sysclk); #1;
        check(name, {31'h0, seen}, 32'h1);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        @(posedge sysclk); #1 rx_valid = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   s0;

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;

        // ---------------- reset state ----------------
        bus.addr = A_CON; bus.MemRead = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_tx_start", {31'h0, tx_start}, 32'h0);
        check("reset_con", bus.rdata, 32'h80);
        bus.MemRead = 1'b0;
        @(negedge sysclk) reset = 1'b1;
        @(posedge sysclk); #1;

        // ---------------- register access table ----------------
        vecs.push_back('{0, 1, A_CON,         32'h0,         32'h80, "con_idle"});
        vecs.push_back('{1, 0, A_CON,         32'h3,         32'h0,  "con_wr_ie"});
        vecs.push_back('{0, 1, A_CON,         32'h0,         32'h83, "con_ie_set"});
        vecs.push_back('{0, 1, A_CON + 32'h4, 32'h0,         32'h0,  "unclaimed_hi"});
        vecs.push_back('{0, 1, BASE - 32'h4,  32'h0,         32'h0,  "unclaimed_lo"});
        vecs.push_back('{0, 0, A_CON,         32'h0,         32'h0,  "no_read_strobe"});
        vecs.push_back('{1, 0, A_CON,         32'hFFFF_FFFE, 32'h0,  "con_wr_rx_ie"});
        vecs.push_back('{0, 1, A_CON,         32'h0,         32'h82, "con_rx_ie_only"});
        vecs.push_back('{1, 0, A_CON,         32'h0,         32'h0,  "con_wr_zero"});
        vecs.push_back('{0, 1, A_CON,         32'h0,         32'h80, "con_cleared"});
        vecs.push_back('{0, 1, A_RXD,         32'h0,         32'h0,  "rxd_reset"});
        foreach (vecs[i]) begin
            bus.addr = vecs[i].addr; bus.wdata = vecs[i].wdata;
            bus.MemWrite = vecs[i].wr; bus.MemRead = vecs[i].rd;
            @(negedge sysclk);
            if (!vecs[i].wr) check(vecs[i].name, bus.rdata, vecs[i].exp);
            @(posedge sysclk); #1;
            bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
        end

        // ---------------- single TX ----------------
        eng_en = 1'b1; busy_len = 10; s0 = n_starts;
        exp_q.push_back(8'h55);
        bus_write(A_TXD, 32'h55);
        read_check(A_TXD, 32'h55, "txd_readback");
        wait_con(32'h84, 100, "single_tx_done");
        check("single_start_count", 32'(n_starts - s0), 32'd1);
        bus_write(A_CON, 32'h04);
        read_check(A_CON, 32'h80, "tx_done_w1c");

        // ---------------- FIFO burst and overflow ----------------
        busy_len = 3; busy_hold = 1'b1; s0 = n_starts;
        for (int i = 1; i <= 5; i++) bus_write(A_TXD, 32'(i));
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        read_check(A_CON, 32'h50, "burst_full_ovf");
        read_check(A_TXD, 32'h05, "txd_last_written");
        busy_hold = 1'b0;
        wait_con(32'hC4, 200, "burst_drained");
        check("burst_start_count", 32'(n_starts - s0), 32'd4);
        bus_write(A_CON, 32'h44);
        read_check(A_CON, 32'h80, "burst_flags_cleared");

        // ---------------- RX and overrun ----------------
        rx_pulse(8'hA5);
        read_check(A_CON, 32'h88, "rx_ready_set");
        read_check(A_RXD, 32'hA5, "rxd_read");
        read_check(A_CON, 32'h80, "rx_ready_cleared");
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        read_check(A_CON, 32'hA8, "rx_ovr_set");
        read_check(A_RXD, 32'h22, "rx_hold_overwritten");
        bus_write(A_CON, 32'h20);
        read_check(A_CON, 32'h80, "rx_ovr_w1c");

        // ---------------- interrupt latency and simultaneity ----------------
        bus_write(A_CON, 32'h3);
        check("irq_quiet", {31'h0, irq}, 32'h0);
        rx_pulse(8'h33);
        @(negedge sysclk) check("irq_not_yet", {31'h0, irq}, 32'h0);
        @(negedge sysclk) check("irq_one_cycle", {31'h0, irq}, 32'h1);
        @(posedge sysclk); #1;
        bus.addr = A_RXD; bus.MemRead = 1'b1; rx_valid = 1'b1; rx_data = 8'h44;
        @(posedge sysclk); #1 rx_valid = 1'b0; bus.MemRead = 1'b0;
        @(negedge sysclk) check("irq_hold_a", {31'h0, irq}, 32'h1);
        @(negedge sysclk) check("irq_hold_b", {31'h0, irq}, 32'h1);
        @(posedge sysclk); #1;
        read_check(A_CON, 32'h8B, "rx_simul_no_ovr");
        read_check(A_RXD, 32'h44, "rx_simul_data");
        read_check(A_CON, 32'h83, "rx_simul_cleared");

        // tx_done W1C colliding with a fresh tx_done
        busy_len = 3;
        exp_q.push_back(8'h66);
        bus_write(A_TXD, 32'h66);
        wait_con(32'h87, 100, "tx_done_ie");
        check("irq_tx_done", {31'h0, irq}, 32'h1);
        eng_en = 1'b0;
        exp_q.push_back(8'h77);
        bus_write(A_TXD, 32'h77);
        wait_start("start_77");
        busy_hold = 1'b1;
        repeat (2) @(posedge sysclk);
        #1 busy_hold = 1'b0;
        bus_write(A_CON, 32'h07);
        read_check(A_CON, 32'h87, "tx_done_set_wins");

        // ---------------- async reset during WAIT_LO ----------------
        exp_q.push_back(8'h88);
        bus_write(A_TXD, 32'h88);
        bus_write(A_TXD, 32'h99);
        wait_start("start_88");
        busy_hold = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        s0 = n_starts;
        bus.addr = A_CON; bus.MemRead = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("midreset_con", bus.rdata, 32'h80);
        check("midreset_tx_start", {31'h0, tx_start}, 32'h0);
        check("midreset_tx_data", {24'h0, tx_data}, 32'h0);
        check("midreset_irq", {31'h0, irq}, 32'h0);
        bus.MemRead = 1'b0;
        @(negedge sysclk) reset = 1'b1;
        repeat (4) @(posedge sysclk);
        #1 busy_hold = 1'b0;
        repeat (20) @(posedge sysclk);
        #1;
        check("no_start_after_reset", 32'(n_starts - s0), 32'd0);
        read_check(A_CON, 32'h80, "post_reset_idle");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
